sys_bridge_mc: RTL and testbench

//  Multi-channel system bridge between the CPU M-stage data port and the peripherals: data memory (DM),
//  NUM_TC timer channels, the interrupt generator (IG) and an internal interrupt controller (INTC).

---
 rtl/sys_bridge_mc_pkg.sv | 30 +++
 rtl/sys_bridge_intc.sv | 58 +++++
 rtl/sys_bridge_mc.sv | 152 +++++++++++++++
 tb/tb_sys_bridge_mc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_bridge_mc_pkg.sv
// Shared codes, register offsets and window helper for the multi-channel system bridge.
// No logic, so it adds no latency and has no backpressure.
// Exception / access-mode encodings match the CPU M-stage data port.
package sys_bridge_mc_pkg;

    localparam logic [4:0] exc_none = 5'd0;
    localparam logic [4:0] exc_adel = 5'd4;
    localparam logic [4:0] exc_ades = 5'd5;

    localparam logic [1:0] dm_rn = 2'd0;
    localparam logic [1:0] dm_rw = 2'd1;
    localparam logic [1:0] dm_rh = 2'd2;
    localparam logic [1:0] dm_rb = 2'd3;

    localparam logic [3:0] dm_wn = 4'd0;
    localparam logic [3:0] dm_ww = 4'd1;
    localparam logic [3:0] dm_wh = 4'd2;
    localparam logic [3:0] dm_wb = 4'd3;

    // word index inside the INTC window
    localparam logic [1:0] bridge_intc_mask    = 2'd0;
    localparam logic [1:0] bridge_intc_pend    = 2'd1;
    localparam logic [1:0] bridge_intc_badaddr = 2'd2;

    function automatic logic win_overlap(input logic [31:0] a_lo, input logic [31:0] a_hi,
                                         input logic [31:0] b_lo, input logic [31:0] b_hi);
        return (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

endpackage

// File: rtl/sys_bridge_intc.sv
// Interrupt controller: timer IRQ edge detect, maskable pending bits, BADADDR capture, register reads.
// Register reads are combinational (the bridge registers them); writes land on the access edge.
// No backpressure: every write and every IRQ edge is accepted in the cycle it occurs.
module sys_bridge_intc
    import sys_bridge_mc_pkg::*;
#(
    parameter int NUM_TC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_TC-1:0] tc_irq,
    input  logic              wr_en,
    input  logic [1:0]        reg_off,
    input  logic [31:0]       wr_data,
    input  logic              exc_vld,
    input  logic [31:0]       bad_addr,
    output logic [31:0]       rd_data,
    output logic [NUM_TC-1:0] irq_out
);

    logic [NUM_TC-1:0] prev;
    logic [NUM_TC-1:0] pending;
    logic [NUM_TC-1:0] mask;
    logic [31:0]       badaddr;
    logic [NUM_TC-1:0] clr;

    assign clr = (wr_en && reg_off == bridge_intc_pend) ? wr_data[NUM_TC-1:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev    <= '0;
            pending <= '0;
            mask    <= '1;
            badaddr <= '0;
        end else begin
            prev    <= tc_irq;
            // new edge is ORed in after the clear so a simultaneous set wins
            pending <= (pending & ~clr) | (tc_irq & ~prev);
            if (wr_en && reg_off == bridge_intc_mask)
                mask <= wr_data[NUM_TC-1:0];
            if (exc_vld)
                badaddr <= bad_addr;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_off)
            bridge_intc_mask:    rd_data = 32'(mask);
            bridge_intc_pend:    rd_data = 32'(pending);
            bridge_intc_badaddr: rd_data = badaddr;
            default:             rd_data = '0;
        endcase
    end

    assign irq_out = pending & mask;

endmodule

// File: rtl/sys_bridge_mc.sv
// Bridge from the CPU M-stage data port to DM, NUM_TC timers, IG and the internal INTC.
// Decode/exceptions/strobes are combinational; read data is registered with 1-cycle latency.
// No backpressure: one access per cycle is always accepted; faulting accesses are squashed.
module sys_bridge_mc
    import sys_bridge_mc_pkg::*;
#(
    parameter int          NUM_TC    = 2,
    parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] TC_BASE   = 32'h0000_7F00,
    parameter logic [31:0] IG_BASE   = 32'h0000_7F20,
    parameter logic [31:0] INTC_BASE = 32'h0000_7F30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [31:0]          m_data_addr,
    input  logic [31:0]          m_data_wdata,
    input  logic [3:0]           m_data_byteen,
    input  logic [1:0]           read_mode,
    input  logic [3:0]           write_mode,
    output logic [31:0]          m_data_rdata,
    output logic                 rdata_valid,
    output logic [4:0]           e_code,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    output logic [3:0]           dm_byteen,
    input  logic [31:0]          dm_rdata,
    output logic [31:0]          ig_addr,
    output logic [3:0]           ig_byteen,
    output logic [31:0]          tc_addr,
    output logic [31:0]          tc_wdata,
    output logic [NUM_TC-1:0]    tc_we,
    input  logic [32*NUM_TC-1:0] tc_rdata,
    input  logic [NUM_TC-1:0]    tc_irq,
    output logic [NUM_TC-1:0]    irq_out,
    output logic                 irq_any
);

    localparam logic [31:0] IG_TOP   = IG_BASE + 32'd3;
    localparam logic [31:0] INTC_TOP = INTC_BASE + 32'd11;

    if (NUM_TC < 1 || NUM_TC > 8) begin : g_bad_num_tc
        $error("sys_bridge_mc: NUM_TC must be 1..8");
    end
    if (win_overlap(32'd0, DM_TOP, IG_BASE, IG_TOP) ||
        win_overlap(32'd0, DM_TOP, INTC_BASE, INTC_TOP) ||
        win_overlap(IG_BASE, IG_TOP, INTC_BASE, INTC_TOP)) begin : g_bad_win
        $error("sys_bridge_mc: DM/IG/INTC windows overlap");
    end

    logic [NUM_TC-1:0] hit_tc;
    logic [NUM_TC-1:0] hit_tc_count;
    logic              hit_dm, hit_ig, hit_intc, any_tc, any_hit;
    logic [1:0]        intc_word;
    logic              rd_req, wr_req, adel, ades, exc;
    logic [31:0]       intc_rdata;
    logic [31:0]       rd_sel;

    for (genvar i = 0; i < NUM_TC; i++) begin : g_tc
        localparam logic [31:0] LO = TC_BASE + 32'(16 * i);
        localparam logic [31:0] HI = LO + 32'd11;
        if (win_overlap(LO, HI, 32'd0, DM_TOP) || win_overlap(LO, HI, IG_BASE, IG_TOP) ||
            win_overlap(LO, HI, INTC_BASE, INTC_TOP)) begin : g_bad_tc_win
            $error("sys_bridge_mc: timer window overlaps another window");
        end
        assign hit_tc[i]       = (m_data_addr >= LO) && (m_data_addr <= HI);
        assign hit_tc_count[i] = hit_tc[i] && (m_data_addr >= LO + 32'd8);
        assign tc_we[i]        = req_valid && hit_tc[i] && (|m_data_byteen) && !exc;
    end

    assign hit_dm   = m_data_addr <= DM_TOP;
    assign hit_ig   = (m_data_addr >= IG_BASE) && (m_data_addr <= IG_TOP);
    assign hit_intc = (m_data_addr >= INTC_BASE) && (m_data_addr <= INTC_TOP);
    assign any_tc   = |hit_tc;
    assign any_hit  = hit_dm || hit_ig || hit_intc || any_tc;

    always_comb begin
        intc_word = bridge_intc_mask;
        if (m_data_addr >= INTC_BASE + 32'd8)
            intc_word = bridge_intc_badaddr;
        else if (m_data_addr >= INTC_BASE + 32'd4)
            intc_word = bridge_intc_pend;
    end

    assign rd_req = req_valid && (read_mode != dm_rn);
    assign wr_req = req_valid && (write_mode != dm_wn);

    assign adel = rd_req && (
                      (hit_dm && ((read_mode == dm_rw && m_data_addr[1:0] != 2'b00) ||
                                  (read_mode == dm_rh && m_data_addr[0]))) ||
                      ((any_tc || hit_intc) && (read_mode == dm_rh || read_mode == dm_rb)) ||
                      !any_hit);

    assign ades = wr_req && (
                      (write_mode == dm_ww && m_data_addr[1:0] != 2'b00) ||
                      (write_mode == dm_wh && m_data_addr[0]) ||
                      ((any_tc || hit_intc) && write_mode != dm_ww) ||
                      (|hit_tc_count) ||
                      (hit_intc && intc_word == bridge_intc_badaddr) ||
                      !any_hit);

    assign exc    = adel || ades;
    assign e_code = adel ? exc_adel : (ades ? exc_ades : exc_none);

    assign dm_addr   = m_data_addr;
    assign dm_wdata  = m_data_wdata;
    assign dm_byteen = (req_valid && hit_dm && !exc) ? m_data_byteen : 4'b0000;
    assign ig_addr   = m_data_addr;
    assign ig_byteen = (req_valid && hit_ig && !exc) ? m_data_byteen : 4'b0000;
    assign tc_addr   = m_data_addr;
    assign tc_wdata  = m_data_wdata;

    sys_bridge_intc #(.NUM_TC(NUM_TC)) u_intc (
        .clk      (clk),
        .reset    (reset),
        .tc_irq   (tc_irq),
        .wr_en    (wr_req && hit_intc && !exc),
        .reg_off  (intc_word),
        .wr_data  (m_data_wdata),
        .exc_vld  (exc),
        .bad_addr (m_data_addr),
        .rd_data  (intc_rdata),
        .irq_out  (irq_out)
    );

    assign irq_any = |irq_out;

    // IG is write-only from the CPU side and reads back as zero
    always_comb begin
        rd_sel = '0;
        if (hit_dm)
            rd_sel = dm_rdata;
        else if (hit_intc)
            rd_sel = intc_rdata;
        for (int i = 0; i < NUM_TC; i++)
            if (hit_tc[i])
                rd_sel = tc_rdata[32*i +: 32];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data_rdata <= '0;
            rdata_valid  <= 1'b0;
        end else if (rd_req && !exc) begin
            m_data_rdata <= rd_sel;
            rdata_valid  <= 1'b1;
        end else begin
            rdata_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sys_bridge_mc.sv
// Directed bench for sys_bridge_mc with NUM_TC=4; read data checked through an expectation queue.
module tb_sys_bridge_mc;
    import sys_bridge_mc_pkg::*;

    localparam int NTC = 4;
    localparam logic [31:0] INTC = 32'h0000_7F50;
    localparam logic [31:0] DMRD = 32'h1234_5678;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [31:0]       m_data_addr, m_data_wdata;
    logic [3:0]        m_data_byteen;
    logic [1:0]        read_mode;
    logic [3:0]        write_mode;
    logic [31:0]       m_data_rdata;
    logic              rdata_valid;
    logic [4:0]        e_code;
    logic [31:0]       dm_addr, dm_wdata, ig_addr, tc_addr, tc_wdata;
    logic [3:0]        dm_byteen, ig_byteen;
    logic [31:0]       dm_rdata;
    logic [NTC-1:0]    tc_we, tc_irq, irq_out;
    logic [32*NTC-1:0] tc_rdata;
    logic              irq_any;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];
    logic        exp_vld = 1'b0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    sys_bridge_mc #(
        .NUM_TC(NTC), .DM_TOP(32'h0000_2FFF), .TC_BASE(32'h0000_7F00),
        .IG_BASE(32'h0000_7F40), .INTC_BASE(INTC)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen), .read_mode(read_mode),
        .write_mode(write_mode), .m_data_rdata(m_data_rdata), .rdata_valid(rdata_valid),
        .e_code(e_code), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen),
        .dm_rdata(dm_rdata), .ig_addr(ig_addr), .ig_byteen(ig_byteen), .tc_addr(tc_addr),
        .tc_wdata(tc_wdata), .tc_we(tc_we), .tc_rdata(tc_rdata), .tc_irq(tc_irq),
        .irq_out(irq_out), .irq_any(irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input logic [1:0] rm, input logic [3:0] wm);
        req_valid     = 1'b1;
        m_data_addr   = a;
        m_data_wdata  = wd;
        m_data_byteen = be;
        read_mode     = rm;
        write_mode    = wm;
        #1;
    endtask

    task automatic idle();
        req_valid     = 1'b0;
        m_data_byteen = 4'h0;
        read_mode     = dm_rn;
        write_mode    = dm_wn;
        #1;
    endtask

    task automatic expect_rd(input logic [31:0] v);
        exp_q.push_back(v);
        exp_vld = 1'b1;
        last_rd = v;
    endtask

    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        chk("rdata_valid", 32'(rdata_valid), 32'(exp_vld));
        if (exp_vld) begin
            e = exp_q.pop_front();
            if (rdata_valid) chk("rdata", m_data_rdata, e);
        end
        exp_vld = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] rm,
                      input logic [31:0] v);
        op(a, 32'h0, 4'h0, rm, dm_wn);
        chk(tag, 32'(e_code), 32'(exc_none));
        expect_rd(v);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        dm_rdata = DMRD;
        tc_rdata = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
        tc_irq = '0;
        m_data_addr = '0;
        m_data_wdata = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", m_data_rdata, 32'h0);
        chk("rst_rvld", 32'(rdata_valid), 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);
        reset = 1'b1;
        tick();

        rd("rd_mask_e", INTC, dm_rw, 32'hF);
        rd("rd_pend_e", INTC + 4, dm_rw, 32'h0);
        rd("rd_bad_e", INTC + 8, dm_rw, 32'h0);

        // 1: timer 3 read
        op(32'h7F34, 32'h0, 4'h0, dm_rw, dm_wn);
        chk("t1_tc_we", 32'(tc_we), 32'h0);
        chk("t1_ecode", 32'(e_code), 32'(exc_none));
        expect_rd(32'hA0A0_0003);
        tick();

        // good timer write, then write to read-only COUNT
        op(32'h7F14, 32'hCAFE_0001, 4'hF, dm_rn, dm_ww);
        chk("tc1_we", 32'(tc_we), 32'h2);
        chk("tc1_wdata", tc_wdata, 32'hCAFE_0001);
        tick();
        op(32'h7F18, 32'h5, 4'hF, dm_rn, dm_ww);
        chk("t2_ecode", 32'(e_code), 32'(exc_ades));
        chk("t2_tc_we", 32'(tc_we), 32'h0);
        tick();
        rd("t2_bad_e", INTC + 8, dm_rw, 32'h7F18);

        // 3: DM alignment and unmapped reads
        op(32'h3, 32'h0, 4'h3, dm_rh, dm_wn);
        chk("t3_lh_ecode", 32'(e_code), 32'(exc_adel));
        chk("t3_dm_be", 32'(dm_byteen), 32'h0);
        tick();
        chk("t3_hold", m_data_rdata, last_rd);
        op(32'h9000, 32'h0, 4'h0, dm_rw, dm_wn);
        chk("t3_lw_ecode", 32'(e_code), 32'(exc_adel));
        tick();
        rd("dm_lw_e", 32'h100, dm_rw, DMRD);
        rd("dm_lh_e", 32'h102, dm_rh, DMRD);
        rd("ig_rd_e", 32'h7F40, dm_rw, 32'h0);
        op(32'h7F00, 32'h0, 4'h0, dm_rb, dm_wn);
        chk("tc_lb_ecode", 32'(e_code), 32'(exc_adel));
        tick();
        op(32'h2FFC, 32'h1, 4'hF, dm_rn, dm_ww);
        chk("dm_sw_be", 32'(dm_byteen), 32'hF);
        chk("dm_sw_ecode", 32'(e_code), 32'(exc_none));
        tick();
        op(32'h3000, 32'h1, 4'h1, dm_rn, dm_wb);
        chk("nohit_sb_ecode", 32'(e_code), 32'(exc_ades));
        chk("nohit_sb_be", 32'(dm_byteen), 32'h0);
        tick();
        op(32'h7F40, 32'h1, 4'h3, dm_rn, dm_wh);
        chk("ig_sh_be", 32'(ig_byteen), 32'h3);
        tick();

        // 4: pending + masking
        idle();
        tc_irq = 4'b0010;
        tick();
        chk("t4_irq_out", 32'(irq_out), 32'h2);
        chk("t4_irq_any", 32'(irq_any), 32'h1);
        rd("t4_pend_e", INTC + 4, dm_rw, 32'h2);
        op(INTC, 32'h0, 4'hF, dm_rn, dm_ww);
        chk("t4_mask_ecode", 32'(e_code), 32'(exc_none));
        tick();
        chk("t4_masked_any", 32'(irq_any), 32'h0);
        rd("t4_pend_held_e", INTC + 4, dm_rw, 32'h2);

        // 5: set wins over W1C on the same edge
        op(INTC, 32'hF, 4'hF, dm_rn, dm_ww);
        tick();
        op(INTC + 4, 32'h3, 4'hF, dm_rn, dm_ww);
        tc_irq = 4'b0011;
        tick();
        chk("t5_irq_out", 32'(irq_out), 32'h1);
        rd("t5_pend_e", INTC + 4, dm_rw, 32'h1);

        // 6: reset in the middle of a MASK write
        tc_irq = '0;
        idle();
        tick();
        op(INTC, 32'h0, 4'hF, dm_rn, dm_ww);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rvld", 32'(rdata_valid), 32'h0);
        chk("t6_irq", 32'(irq_out), 32'h0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("t6_rdata", m_data_rdata, 32'h0);
        rd("t6_mask_e", INTC, dm_rw, 32'hF);
        rd("t6_pend_e", INTC + 4, dm_rw, 32'h0);
        rd("t6_bad_e", INTC + 8, dm_rw, 32'h0);
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
